// File: rtl/padd_chain_if.sv
`default_nettype none
// ============================================================================
// Module   : padd_chain_if
// Purpose  : Sample/result bundle for padd_chain: control, operands, cascade
//            outputs and the registered pre-adder result.
// Revision : 1.0 - initial release
// ============================================================================
interface padd_chain_if #(
    parameter int WIDTH = 18
);
    logic             ce;
    logic             flush;
    logic             in_valid;
    logic             sub;
    logic [WIDTH-1:0] si;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] so;
    logic [WIDTH-1:0] sbo;
    logic [WIDTH+1:0] dout;
    logic [WIDTH-1:0] sat_out;
    logic             ovf;
    logic             out_valid;

    modport master (
        output ce, flush, in_valid, sub, si, b,
        input  so, sbo, dout, sat_out, ovf, out_valid
    );

    modport slave (
        input  ce, flush, in_valid, sub, si, b,
        output so, sbo, dout, sat_out, ovf, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/padd_chain.sv
`default_nettype none
// ============================================================================
// Module   : padd_chain
// Purpose  : Pipelined pre-adder dout = si[n-(DEPTH-1)] +/- b[n] with an SI
//            delay chain, saturation, overflow flag and valid tracking.
// Revision : 1.0 - initial release
// ============================================================================
module padd_chain #(
    parameter int WIDTH  = 18,
    parameter int DEPTH  = 4,
    parameter int SIGNED = 1
) (
    input  wire logic   clk,
    input  wire logic   reset_n,
    padd_chain_if.slave bus
);
    localparam int FW = $clog2(DEPTH + 1);
    localparam logic [FW-1:0] c_fill_full  = FW'(DEPTH);
    localparam logic [FW-1:0] c_fill_ready = FW'(DEPTH - 1);
    localparam logic [FW-1:0] c_fill_one   = FW'(1);

    logic [WIDTH-1:0] r_chain [DEPTH];
    logic [WIDTH-1:0] r_b;
    logic             r_sub;
    logic [FW-1:0]    r_fill;
    logic             r_v1;

    logic [WIDTH+1:0] r_dout;
    logic [WIDTH-1:0] r_sat;
    logic             r_ovf;
    logic             r_out_valid;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH+1:0] w_a_ext;
    logic [WIDTH+1:0] w_b_ext;
    logic [WIDTH+1:0] w_sum;
    logic [WIDTH-1:0] w_sat;
    logic             w_over;

    // Stage 1: delay chain and operand B register. Only accepted samples shift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_chain[i] <= '0;
            r_b    <= '0;
            r_sub  <= 1'b0;
            r_fill <= '0;
            r_v1   <= 1'b0;
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) r_chain[i] <= '0;
            r_b    <= '0;
            r_fill <= '0;
            r_v1   <= 1'b0;
        end else if (bus.ce) begin
            // Valid once the chain already holds DEPTH-1 older samples.
            r_v1 <= bus.in_valid & (r_fill >= c_fill_ready);
            if (bus.in_valid) begin
                r_chain[0] <= bus.si;
                for (int i = 1; i < DEPTH; i++) r_chain[i] <= r_chain[i-1];
                r_b    <= bus.b;
                r_sub  <= bus.sub;
                r_fill <= (r_fill == c_fill_full) ? r_fill : r_fill + c_fill_one;
            end
        end
    end

    assign w_a = r_chain[DEPTH-1];

    if (SIGNED != 0) begin : g_signed
        assign w_a_ext = {{2{w_a[WIDTH-1]}}, w_a};
        assign w_b_ext = {{2{r_b[WIDTH-1]}}, r_b};
        // Fits WIDTH only when the three top bits agree.
        assign w_over  = (w_sum[WIDTH+1:WIDTH-1] != 3'b000) &&
                         (w_sum[WIDTH+1:WIDTH-1] != 3'b111);
        assign w_sat   = !w_over        ? w_sum[WIDTH-1:0] :
                         w_sum[WIDTH+1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                          {1'b0, {(WIDTH-1){1'b1}}};
    end else begin : g_unsigned
        assign w_a_ext = {2'b00, w_a};
        assign w_b_ext = {2'b00, r_b};
        // Negative (sub underflow) or carry beyond WIDTH bits.
        assign w_over  = w_sum[WIDTH+1] | w_sum[WIDTH];
        assign w_sat   = !w_over        ? w_sum[WIDTH-1:0] :
                         w_sum[WIDTH+1] ? {WIDTH{1'b0}} :
                                          {WIDTH{1'b1}};
    end

    assign w_sum = r_sub ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);

    // Stage 2: full-precision result, clamped copy and valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout      <= '0;
            r_sat       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (bus.flush) begin
            r_dout      <= '0;
            r_sat       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (bus.ce) begin
            r_dout      <= w_sum;
            r_sat       <= w_sat;
            r_ovf       <= w_over;
            r_out_valid <= r_v1;
        end
    end

    assign bus.so        = w_a;
    assign bus.sbo       = r_b;
    assign bus.dout      = r_dout;
    assign bus.sat_out   = r_sat;
    assign bus.ovf       = r_ovf;
    assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_padd_chain.sv
`default_nettype none
// ============================================================================
// Module   : tb_padd_chain
// Purpose  : Self-checking bench for padd_chain (D=3 signed, D=1 signed,
//            D=1 unsigned) using per-instance expected-result queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_padd_chain;
    localparam int W = 18;

    typedef struct packed {
        logic [W+1:0] dout;
        logic [W-1:0] sat;
        logic         ovf;
    } res_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    padd_chain_if #(.WIDTH(W)) ifa ();
    padd_chain_if #(.WIDTH(W)) ifb ();
    padd_chain_if #(.WIDTH(W)) ifc ();

    padd_chain #(.WIDTH(W), .DEPTH(3), .SIGNED(1)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
    padd_chain #(.WIDTH(W), .DEPTH(1), .SIGNED(1)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));
    padd_chain #(.WIDTH(W), .DEPTH(1), .SIGNED(0)) dut_c (.clk(clk), .reset_n(reset_n), .bus(ifc));

    int   checks = 0;
    int   errors = 0;
    res_t qa[$], qb[$], qc[$];
    int   hist_a[$];
    bit   pend_a = 1'b0;
    bit   en_a, en_b, en_c;
    res_t ea, eb, ec;

    function automatic res_t model(input int a, input int bv, input logic sb, input bit sgn);
        res_t r;
        int   s;
        int   lo;
        int   hi;
        s  = sb ? (a - bv) : (a + bv);
        lo = sgn ? -(1 << (W-1)) : 0;
        hi = sgn ? (1 << (W-1)) - 1 : (1 << W) - 1;
        r.dout = s[W+1:0];
        if (s > hi) begin
            r.sat = hi[W-1:0]; r.ovf = 1'b1;
        end else if (s < lo) begin
            r.sat = lo[W-1:0]; r.ovf = 1'b1;
        end else begin
            r.sat = s[W-1:0];  r.ovf = 1'b0;
        end
        return r;
    endfunction

    // One clock of stimulus on instance `which`; expectations queued as it is driven.
    task automatic drive(input int which, input bit ce, input bit fl, input bit iv,
                         input bit sb, input int si_v, input int b_v);
        case (which)
            0: begin ifa.ce = ce; ifa.flush = fl; ifa.in_valid = iv; ifa.sub = sb; ifa.si = si_v[W-1:0]; ifa.b = b_v[W-1:0]; end
            1: begin ifb.ce = ce; ifb.flush = fl; ifb.in_valid = iv; ifb.sub = sb; ifb.si = si_v[W-1:0]; ifb.b = b_v[W-1:0]; end
            default: begin ifc.ce = ce; ifc.flush = fl; ifc.in_valid = iv; ifc.sub = sb; ifc.si = si_v[W-1:0]; ifc.b = b_v[W-1:0]; end
        endcase
        if (which == 0) begin
            if (fl) begin
                if (pend_a) void'(qa.pop_back());
                pend_a = 1'b0;
                hist_a.delete();
            end else if (ce) begin
                pend_a = 1'b0;
                if (iv) begin
                    hist_a.push_back(si_v);
                    if (hist_a.size() >= 3) begin
                        qa.push_back(model(hist_a[hist_a.size()-3], b_v, sb, 1'b1));
                        pend_a = 1'b1;
                    end
                end
            end
        end else if (ce && iv && !fl) begin
            if (which == 1) qb.push_back(model(si_v, b_v, sb, 1'b1));
            else            qc.push_back(model(si_v, b_v, sb, 1'b0));
        end
        @(posedge clk); #1;
        ifa.in_valid = 1'b0; ifa.flush = 1'b0; ifa.ce = 1'b1;
        ifb.in_valid = 1'b0; ifb.flush = 1'b0; ifb.ce = 1'b1;
        ifc.in_valid = 1'b0; ifc.flush = 1'b0; ifc.ce = 1'b1;
    endtask

    always @(posedge clk) begin
        en_a = reset_n & ifa.ce & ~ifa.flush;
        en_b = reset_n & ifb.ce & ~ifb.flush;
        en_c = reset_n & ifc.ce & ~ifc.flush;
    end

    always @(negedge clk) begin
        if (en_a && ifa.out_valid) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL sb_a: unexpected out_valid, dout=%h, expected no result", ifa.dout);
            end else begin
                ea = qa.pop_front();
                if ({ifa.dout, ifa.sat_out, ifa.ovf} !== ea) begin
                    errors++;
                    $display("FAIL sb_a: got dout=%h sat=%h ovf=%b, expected dout=%h sat=%h ovf=%b",
                             ifa.dout, ifa.sat_out, ifa.ovf, ea.dout, ea.sat, ea.ovf);
                end
            end
        end
        if (en_b && ifb.out_valid) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL sb_b: unexpected out_valid, dout=%h, expected no result", ifb.dout);
            end else begin
                eb = qb.pop_front();
                if ({ifb.dout, ifb.sat_out, ifb.ovf} !== eb) begin
                    errors++;
                    $display("FAIL sb_b: got dout=%h sat=%h ovf=%b, expected dout=%h sat=%h ovf=%b",
                             ifb.dout, ifb.sat_out, ifb.ovf, eb.dout, eb.sat, eb.ovf);
                end
            end
        end
        if (en_c && ifc.out_valid) begin
            checks++;
            if (qc.size() == 0) begin
                errors++;
                $display("FAIL sb_c: unexpected out_valid, dout=%h, expected no result", ifc.dout);
            end else begin
                ec = qc.pop_front();
                if ({ifc.dout, ifc.sat_out, ifc.ovf} !== ec) begin
                    errors++;
                    $display("FAIL sb_c: got dout=%h sat=%h ovf=%b, expected dout=%h sat=%h ovf=%b",
                             ifc.dout, ifc.sat_out, ifc.ovf, ec.dout, ec.sat, ec.ovf);
                end
            end
        end
    end

    task automatic test_drain();
        for (int i = 0; i < 12 && (qa.size() + qb.size() + qc.size()) != 0; i++)
            drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        @(negedge clk); #1;
        checks++;
        if (qa.size() + qb.size() + qc.size() != 0) begin
            errors++;
            $display("FAIL drain: outstanding results a=%0d b=%0d c=%0d, expected 0",
                     qa.size(), qb.size(), qc.size());
            qa.delete(); qb.delete(); qc.delete();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ifa.dout, ifa.sat_out, ifa.ovf, ifa.out_valid, ifa.so, ifa.sbo,
             ifb.dout, ifb.out_valid, ifc.dout, ifc.out_valid} !== '0) begin
            errors++;
            $display("FAIL reset: a.dout=%h a.valid=%b a.so=%h a.sbo=%h b.dout=%h c.dout=%h, expected all 0",
                     ifa.dout, ifa.out_valid, ifa.so, ifa.sbo, ifb.dout, ifc.dout);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Stream 1..5 with b=10: first valid exactly two edges after the 3rd sample.
    task automatic test_fill();
        for (int i = 1; i <= 5; i++) begin
            drive(0, 1'b1, 1'b0, 1'b1, 1'b0, i, 10);
            if (i == 3) begin
                @(negedge clk);
                checks++;
                if (ifa.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_latency: out_valid=%b one edge after 3rd sample, expected 0", ifa.out_valid);
                end
            end else if (i == 4) begin
                @(negedge clk);
                checks++;
                if (ifa.out_valid !== 1'b1 || ifa.dout !== 20'd11) begin
                    errors++;
                    $display("FAIL fill_first: out_valid=%b dout=%0d, expected 1 and 11", ifa.out_valid, ifa.dout);
                end
            end
        end
        test_drain();
    endtask

    task automatic test_bubble_ce();
        logic [W+1:0] f_dout;
        logic         f_valid;
        logic [W-1:0] f_so, f_sbo;
        drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 10);
        drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 2, 10);
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 77, 99);
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 88, 99);
        drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 3, 10);
        drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 4, 10);
        @(negedge clk);
        f_dout = ifa.dout; f_valid = ifa.out_valid; f_so = ifa.so; f_sbo = ifa.sbo;
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b0, 1'b0, 1'b1, 1'b1, 500 + k, 600);
            @(negedge clk);
            checks++;
            if (ifa.dout !== f_dout || ifa.out_valid !== f_valid || ifa.so !== f_so || ifa.sbo !== f_sbo) begin
                errors++;
                $display("FAIL ce_freeze: dout=%h valid=%b so=%h sbo=%h, expected dout=%h valid=%b so=%h sbo=%h",
                         ifa.dout, ifa.out_valid, ifa.so, ifa.sbo, f_dout, f_valid, f_so, f_sbo);
            end
        end
        drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 5, 10);
        test_drain();
    endtask

    task automatic test_flush();
        drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        for (int i = 1; i <= 4; i++) drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 10 * i, 5);
        // Flush with ce low and a sample offered: flush must still win.
        drive(0, 1'b0, 1'b1, 1'b1, 1'b0, 999, 999);
        @(negedge clk);
        checks++;
        if (ifa.out_valid !== 1'b0 || ifa.dout !== '0 || ifa.so !== '0 || ifa.sbo !== '0) begin
            errors++;
            $display("FAIL flush_clear: valid=%b dout=%h so=%h sbo=%h, expected all 0",
                     ifa.out_valid, ifa.dout, ifa.so, ifa.sbo);
        end
        drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 100, 7);
        drive(0, 1'b1, 1'b0, 1'b1, 1'b1, -200, 7);
        drive(0, 1'b1, 1'b0, 1'b1, 1'b1, 300, -50);
        drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 400, 131000);
        drive(0, 1'b1, 1'b0, 1'b1, 1'b1, -131072, 131071);
        drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 6, -131072);
        test_drain();
    endtask

    task automatic test_sat_signed();
        drive(1, 1'b1, 1'b0, 1'b1, 1'b0, 131071, 1);
        drive(1, 1'b1, 1'b0, 1'b1, 1'b1, -131072, 1);
        @(negedge clk);
        checks++;
        if (ifb.dout !== 20'h20000 || ifb.sat_out !== 18'h1FFFF || ifb.ovf !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos: dout=%h sat=%h ovf=%b, expected 20000 1ffff 1", ifb.dout, ifb.sat_out, ifb.ovf);
        end
        drive(1, 1'b1, 1'b0, 1'b1, 1'b0, -5, 3);
        drive(1, 1'b1, 1'b0, 1'b1, 1'b1, 100, -50);
        drive(1, 1'b1, 1'b0, 1'b1, 1'b1, 131071, -131072);
        drive(1, 1'b1, 1'b0, 1'b1, 1'b0, -131072, -131072);
        drive(1, 1'b1, 1'b0, 1'b1, 1'b0, 131071, -1);
        test_drain();
    endtask

    task automatic test_sat_unsigned();
        drive(2, 1'b1, 1'b0, 1'b1, 1'b1, 5, 9);
        drive(2, 1'b1, 1'b0, 1'b1, 1'b0, 262143, 1);
        @(negedge clk);
        checks++;
        if (ifc.dout !== 20'hFFFFC || ifc.sat_out !== 18'h0 || ifc.ovf !== 1'b1) begin
            errors++;
            $display("FAIL usat_neg: dout=%h sat=%h ovf=%b, expected ffffc 0 1", ifc.dout, ifc.sat_out, ifc.ovf);
        end
        drive(2, 1'b1, 1'b0, 1'b1, 1'b0, 262143, 262143);
        drive(2, 1'b1, 1'b0, 1'b1, 1'b1, 100, 40);
        drive(2, 1'b1, 1'b0, 1'b1, 1'b1, 0, 262143);
        drive(2, 1'b1, 1'b0, 1'b1, 1'b0, 131072, 131071);
        test_drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 4; i++) drive(0, 1'b1, 1'b0, 1'b1, 1'b0, i, 10);
        test_drain();
        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({ifa.dout, ifa.sat_out, ifa.ovf, ifa.out_valid, ifa.so, ifa.sbo} !== '0) begin
            errors++;
            $display("FAIL async_reset: dout=%h sat=%h ovf=%b valid=%b so=%h sbo=%h, expected all 0",
                     ifa.dout, ifa.sat_out, ifa.ovf, ifa.out_valid, ifa.so, ifa.sbo);
        end
        #1 reset_n = 1'b1;
        hist_a.delete();
        pend_a = 1'b0;
        @(posedge clk); #1;
        for (int i = 1; i <= 5; i++) drive(0, 1'b1, 1'b0, 1'b1, 1'b0, i, 10);
        test_drain();
    endtask

    initial begin
        ifa.ce = 1'b1; ifa.flush = 1'b0; ifa.in_valid = 1'b0; ifa.sub = 1'b0; ifa.si = '0; ifa.b = '0;
        ifb.ce = 1'b1; ifb.flush = 1'b0; ifb.in_valid = 1'b0; ifb.sub = 1'b0; ifb.si = '0; ifb.b = '0;
        ifc.ce = 1'b1; ifc.flush = 1'b0; ifc.in_valid = 1'b0; ifc.sub = 1'b0; ifc.si = '0; ifc.b = '0;
        test_reset();
        test_fill();
        test_bubble_ce();
        test_flush();
        test_sat_signed();
        test_sat_unsigned();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
